// File: rtl/board_mem_arbiter.sv
// Shares the board BRAM port between the renderer, the generation updater and the cell-edit path.
// Optional ARB_OVERRUN_DETECT_EN adds overrun_out / overrun_count_out for generations spanning blanks.
module board_mem_arbiter #(
  parameter int unsigned WORD_SIZE     = 16,
  parameter int unsigned LOG_WORD_SIZE = 4,
  parameter int unsigned LOG_MAX_ADDR  = 12,
  parameter int unsigned READ_LATENCY  = 2
) (
  input  logic                     clk_130mhz,
  input  logic                     rst_in,
  input  logic                     render_done_in,
  input  logic [LOG_MAX_ADDR-1:0]  render_addr_in,
  input  logic                     step_req_in,
  output logic                     upd_start_out,
  input  logic                     upd_busy_in,
  output logic                     upd_gnt_out,
  input  logic [LOG_MAX_ADDR-1:0]  upd_addr_in,
  input  logic                     upd_we_in,
  input  logic [WORD_SIZE-1:0]     upd_wdata_in,
  input  logic                     edit_req_in,
  input  logic [LOG_MAX_ADDR-1:0]  edit_addr_in,
  input  logic [LOG_WORD_SIZE-1:0] edit_bit_in,
  output logic                     edit_ack_out,
  output logic [LOG_MAX_ADDR-1:0]  mem_addr_out,
  output logic                     mem_we_out,
  output logic [WORD_SIZE-1:0]     mem_wdata_out,
  input  logic [WORD_SIZE-1:0]     mem_rdata_in
`ifdef ARB_OVERRUN_DETECT_EN
  ,
  output logic                     overrun_out,
  output logic [15:0]              overrun_count_out
`endif
);

  localparam int unsigned WaitW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StEditRd,
    StEditWait,
    StEditWr,
    StUpdate
  } state_e;

  state_e                   state_q;
  logic                     step_pending_q;
  logic                     upd_start_q;
  logic [LOG_MAX_ADDR-1:0]  edit_addr_q;
  logic [LOG_WORD_SIZE-1:0] edit_bit_q;
  logic [WORD_SIZE-1:0]     edit_rdata_q;
  logic [WaitW-1:0]         wait_cnt_q;
  logic [WORD_SIZE-1:0]     toggle_mask;

  // Bit 0 addresses the word MSB.
  assign toggle_mask   = {1'b1, {(WORD_SIZE-1){1'b0}}} >> edit_bit_q;
  assign upd_start_out = upd_start_q;

  always_ff @(posedge clk_130mhz or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= StIdle;
      step_pending_q <= 1'b0;
      upd_start_q    <= 1'b0;
      edit_addr_q    <= '0;
      edit_bit_q     <= '0;
      edit_rdata_q   <= '0;
      wait_cnt_q     <= '0;
    end else begin
      upd_start_q    <= 1'b0;
      step_pending_q <= step_pending_q | step_req_in;
      case (state_q)
        StIdle: begin
          if (render_done_in) begin
            if (edit_req_in && !upd_busy_in) begin
              state_q     <= StEditRd;
              edit_addr_q <= edit_addr_in;
              edit_bit_q  <= edit_bit_in;
            end else if (upd_busy_in) begin
              // Resume a generation paused by the previous frame.
              state_q <= StUpdate;
            end else if (step_pending_q || step_req_in) begin
              state_q        <= StUpdate;
              upd_start_q    <= 1'b1;
              step_pending_q <= 1'b0;
            end
          end
        end
        StEditRd: begin
          if (!render_done_in) begin
            state_q <= StIdle;
          end else if (READ_LATENCY == 1) begin
            edit_rdata_q <= mem_rdata_in;
            state_q      <= StEditWr;
          end else begin
            wait_cnt_q <= '0;
            state_q    <= StEditWait;
          end
        end
        StEditWait: begin
          if (!render_done_in) begin
            state_q <= StIdle;
          end else if (wait_cnt_q == WaitW'(READ_LATENCY - 2)) begin
            edit_rdata_q <= mem_rdata_in;
            state_q      <= StEditWr;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StEditWr: begin
          state_q <= StIdle;
        end
        StUpdate: begin
          // The start-pulse cycle is the updater's grace cycle to raise busy.
          if (!render_done_in || (!upd_start_q && !upd_busy_in)) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Renderer owns the port whenever it is drawing, whatever the state.
  always_comb begin
    mem_addr_out  = render_addr_in;
    mem_we_out    = 1'b0;
    mem_wdata_out = '0;
    upd_gnt_out   = 1'b0;
    edit_ack_out  = 1'b0;
    if (render_done_in) begin
      case (state_q)
        StUpdate: begin
          upd_gnt_out   = 1'b1;
          mem_addr_out  = upd_addr_in;
          mem_we_out    = upd_we_in;
          mem_wdata_out = upd_wdata_in;
        end
        StEditRd, StEditWait: begin
          mem_addr_out = edit_addr_q;
        end
        StEditWr: begin
          mem_addr_out  = edit_addr_q;
          mem_we_out    = 1'b1;
          mem_wdata_out = edit_rdata_q ^ toggle_mask;
          edit_ack_out  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ARB_OVERRUN_DETECT_EN
  logic render_done_q;

  always_ff @(posedge clk_130mhz or negedge rst_in) begin
    if (!rst_in) begin
      render_done_q     <= 1'b0;
      overrun_out       <= 1'b0;
      overrun_count_out <= '0;
    end else begin
      render_done_q <= render_done_in;
      if (render_done_q && !render_done_in && upd_busy_in) begin
        overrun_out <= 1'b1;
        if (overrun_count_out != 16'hFFFF) begin
          overrun_count_out <= overrun_count_out + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Randomized bench for board_mem_arbiter: behavioural BRAM, updater and port-ownership model,
// plus directed literal checks for reset, renderer priority, edit RMW, pause/resume and abort.
module tb_board_mem_arbiter;

  localparam int unsigned WS  = 16;
  localparam int unsigned LWS = 4;
  localparam int unsigned LMA = 12;
  localparam int unsigned RL  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            done;
  logic [LMA-1:0]  rend_addr;
  logic            step_req;
  logic            upd_start;
  logic            upd_busy;
  logic            upd_gnt;
  logic [LMA-1:0]  upd_addr;
  logic            upd_we;
  logic [WS-1:0]   upd_wdata;
  logic            edit_req;
  logic [LMA-1:0]  edit_addr;
  logic [LWS-1:0]  edit_bit;
  logic            edit_ack;
  logic [LMA-1:0]  mem_addr;
  logic            mem_we;
  logic [WS-1:0]   mem_wdata;
  logic [WS-1:0]   mem_rdata;
`ifdef ARB_OVERRUN_DETECT_EN
  logic            overrun;
  logic [15:0]     overrun_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  board_mem_arbiter #(
    .WORD_SIZE    (WS),
    .LOG_WORD_SIZE(LWS),
    .LOG_MAX_ADDR (LMA),
    .READ_LATENCY (RL)
  ) dut (
    .clk_130mhz    (clk),
    .rst_in        (rst_n),
    .render_done_in(done),
    .render_addr_in(rend_addr),
    .step_req_in   (step_req),
    .upd_start_out (upd_start),
    .upd_busy_in   (upd_busy),
    .upd_gnt_out   (upd_gnt),
    .upd_addr_in   (upd_addr),
    .upd_we_in     (upd_we),
    .upd_wdata_in  (upd_wdata),
    .edit_req_in   (edit_req),
    .edit_addr_in  (edit_addr),
    .edit_bit_in   (edit_bit),
    .edit_ack_out  (edit_ack),
    .mem_addr_out  (mem_addr),
    .mem_we_out    (mem_we),
    .mem_wdata_out (mem_wdata),
    .mem_rdata_in  (mem_rdata)
`ifdef ARB_OVERRUN_DETECT_EN
    ,
    .overrun_out      (overrun),
    .overrun_count_out(overrun_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // BRAM: data for the address of cycle c is visible during cycle c+RL-1.
  logic [WS-1:0]  bmem [4096];
  logic           poke_en = 1'b0;
  logic [LMA-1:0] poke_addr;
  logic [WS-1:0]  poke_data;

  always @(posedge clk) begin
    if (mem_we) bmem[mem_addr] <= mem_wdata;
    if (poke_en) bmem[poke_addr] <= poke_data;
    mem_rdata <= bmem[mem_addr];
  end

  // Updater: busy from the cycle after start until gen_len granted cycles are used up.
  int gen_left;
  int gen_len_cfg = 3;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_busy <= 1'b0;
      gen_left <= 0;
    end else if (upd_start) begin
      upd_busy <= 1'b1;
      gen_left <= (gen_len_cfg > 0) ? gen_len_cfg : int'($urandom_range(1, 12));
    end else if (upd_busy && upd_gnt) begin
      if (gen_left <= 1) begin
        upd_busy <= 1'b0;
        gen_left <= 0;
      end else begin
        gen_left <= gen_left - 1;
      end
    end
  end

  // Model: who owns the port this cycle, and how far the current operation has progressed.
  logic           m_pend;
  logic           m_upd;
  int             m_upd_cyc;
  int             m_edit;      // 0 none, 1 read, 2..RL wait, RL+1 write
  logic           m_start;
  logic [LMA-1:0] e_addr;
  logic [LWS-1:0] e_bit;
  logic           m_done_prev;
  logic           m_ovr;
  logic [15:0]    m_ovr_cnt;

  function automatic logic [LMA-1:0] exp_addr();
    if (!done) return rend_addr;
    if (m_upd) return upd_addr;
    if (m_edit != 0) return e_addr;
    return rend_addr;
  endfunction

  function automatic logic exp_we();
    if (!done) return 1'b0;
    if (m_upd) return upd_we;
    return m_edit == int'(RL) + 1;
  endfunction

  function automatic logic [WS-1:0] exp_wdata();
    if (m_upd) return upd_wdata;
    return bmem[e_addr] ^ (16'h8000 >> e_bit);
  endfunction

  function automatic logic start_fires();
    return !m_upd && m_edit == 0 && done && !upd_busy && !edit_req && (m_pend || step_req);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend      <= 1'b0;
      m_upd       <= 1'b0;
      m_upd_cyc   <= 0;
      m_edit      <= 0;
      m_start     <= 1'b0;
      e_addr      <= '0;
      e_bit       <= '0;
      m_done_prev <= 1'b0;
      m_ovr       <= 1'b0;
      m_ovr_cnt   <= '0;
    end else begin
      check("m_addr",  32'(mem_addr),  32'(exp_addr()));
      check("m_we",    32'(mem_we),    32'(exp_we()));
      check("m_gnt",   32'(upd_gnt),   32'(m_upd && done));
      check("m_ack",   32'(edit_ack),  32'(m_edit == int'(RL) + 1 && done));
      check("m_start", 32'(upd_start), 32'(m_start));
      if (exp_we()) check("m_wdata", 32'(mem_wdata), 32'(exp_wdata()));
`ifdef ARB_OVERRUN_DETECT_EN
      check("m_overrun", 32'(overrun), 32'(m_ovr));
      check("m_ovr_cnt", 32'(overrun_count), 32'(m_ovr_cnt));
      if (m_done_prev && !done && upd_busy) begin
        m_ovr <= 1'b1;
        if (m_ovr_cnt != 16'hFFFF) m_ovr_cnt <= m_ovr_cnt + 16'd1;
      end
`endif
      m_done_prev <= done;
      m_start     <= start_fires();
      m_pend      <= (m_pend || step_req) && !start_fires();
      if (m_upd) begin
        if (!done || (m_upd_cyc >= 1 && !upd_busy)) m_upd <= 1'b0;
        else m_upd_cyc <= m_upd_cyc + 1;
      end else if (m_edit != 0) begin
        if (!done || m_edit == int'(RL) + 1) m_edit <= 0;
        else m_edit <= m_edit + 1;
      end else if (done) begin
        if (edit_req && !upd_busy) begin
          m_edit <= 1;
          e_addr <= edit_addr;
          e_bit  <= edit_bit;
        end else if (upd_busy) begin
          m_upd     <= 1'b1;
          m_upd_cyc <= 1;
        end else if (m_pend || step_req) begin
          m_upd     <= 1'b1;
          m_upd_cyc <= 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of cycles until the selected signal is seen high (-1 on timeout).
  // which: 0 edit_ack, 1 upd_start, 2 updater idle. Leaves time mid-cycle of the hit.
  task automatic wait_high(input int which, input int limit, output int cycles);
    logic s;
    cycles = -1;
    for (int i = 0; i < limit; i++) begin
      #3;
      case (which)
        0:       s = edit_ack;
        1:       s = upd_start;
        default: s = !upd_busy;
      endcase
      if (s) begin
        cycles = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic poke(input logic [LMA-1:0] a, input logic [WS-1:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  int  n;
  int  blank_left;
  logic ack_seen;

  initial begin
    rst_n = 1'b1; done = 1'b0; rend_addr = 12'h123; step_req = 1'b0;
    upd_addr = '0; upd_we = 1'b0; upd_wdata = '0;
    edit_req = 1'b0; edit_addr = '0; edit_bit = '0;
    poke_addr = '0; poke_data = '0;

    // Asynchronous reset with no clock edge yet.
    #1 rst_n = 1'b0;
    #2;
    check("rst_gnt",   32'(upd_gnt),   32'd0);
    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_ack",   32'(edit_ack),  32'd0);
    check("rst_start", 32'(upd_start), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_addr",  32'(mem_addr),  32'h123);
    tick(); tick();
    rst_n = 1'b1;

    // Renderer priority: edit and step requested while drawing.
    edit_req = 1'b1; edit_addr = 12'h007; edit_bit = 4'd3; step_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rend_addr = LMA'($urandom);
      #3;
      check("rend_addr",  32'(mem_addr),  32'(rend_addr));
      check("rend_we",    32'(mem_we),    32'd0);
      check("rend_ack",   32'(edit_ack),  32'd0);
      check("rend_start", 32'(upd_start), 32'd0);
      tick();
      step_req = 1'b0;
    end
    // Blank: the held edit runs first, then the pending step starts.
    done = 1'b1;
    wait_high(0, 20, n);
    check("edit_first_lat", 32'(n), 32'd3);
    tick();
    edit_req = 1'b0;
    #3 check("start_after_edit0", 32'(upd_start), 32'd0);
    tick();
    #3 check("start_after_edit1", 32'(upd_start), 32'd1);
    tick();
    wait_high(2, 30, n);
    check("gen1_done", 32'(n >= 0), 32'd1);
    tick(); tick();

    // Edit RMW: 0x8001 bit 15 -> 0x8000, then bit 0 -> 0x0000.
    poke(12'h005, 16'h8001);
    edit_req = 1'b1; edit_addr = 12'h005; edit_bit = 4'd15;
    tick();
    #3 check("rmw_rd_addr", 32'(mem_addr), 32'h005);
    check("rmw_rd_we", 32'(mem_we), 32'd0);
    tick(); tick();
    #3 check("rmw_wr_we", 32'(mem_we), 32'd1);
    check("rmw_wr_addr",  32'(mem_addr),  32'h005);
    check("rmw_wr_data",  32'(mem_wdata), 32'h8000);
    check("rmw_ack",      32'(edit_ack),  32'd1);
    tick();
    edit_req = 1'b0;
    #3 check("rmw_ack_pulse", 32'(edit_ack), 32'd0);
    tick();
    edit_req = 1'b1; edit_bit = 4'd0;
    wait_high(0, 20, n);
    check("rmw2_lat",  32'(n),         32'd3);
    check("rmw2_data", 32'(mem_wdata), 32'h0000);
    tick();
    edit_req = 1'b0;
    tick();

    // Step during blank, then pause across a frame and resume.
    gen_len_cfg = 6;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    #3 check("step_start", 32'(upd_start), 32'd1);
    check("step_gnt", 32'(upd_gnt), 32'd1);
    tick();
    #3 check("step_start_pulse", 32'(upd_start), 32'd0);
    tick(); tick();
    done = 1'b0;
    #3 check("pause_gnt", 32'(upd_gnt), 32'd0);
    check("pause_addr", 32'(mem_addr), 32'(rend_addr));
    for (int i = 0; i < 3; i++) begin
      tick();
      #3 check("pause_start", 32'(upd_start), 32'd0);
    end
    tick();
    done = 1'b1;
    #3 check("resume_gnt0", 32'(upd_gnt), 32'd0);
    tick();
    #3 check("resume_gnt1", 32'(upd_gnt), 32'd1);
    check("resume_nostart", 32'(upd_start), 32'd0);
`ifdef ARB_OVERRUN_DETECT_EN
    check("overrun",     32'(overrun),       32'd1);
    check("overrun_cnt", 32'(overrun_count), 32'd1);
`endif
    tick();
    wait_high(2, 30, n);
    check("gen2_done", 32'(n >= 0), 32'd1);
    check("busy_fall_gnt", 32'(upd_gnt), 32'd1);
    tick();
    #3 check("idle_after_gen", 32'(upd_gnt), 32'd0);
    tick();

    // Abort an edit in its wait cycle, then retry in the next blank.
    poke(12'h009, 16'h1234);
    edit_req = 1'b1; edit_addr = 12'h009; edit_bit = 4'd4;
    tick(); tick();
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3 check("abort_we", 32'(mem_we), 32'd0);
      check("abort_ack", 32'(edit_ack), 32'd0);
      tick();
    end
    done = 1'b1;
    wait_high(0, 20, n);
    check("retry_lat",  32'(n),         32'd3);
    check("retry_data", 32'(mem_wdata), 32'h1A34);
    check("retry_addr", 32'(mem_addr),  32'h009);
    tick();
    edit_req = 1'b0;
    tick();

    // Reset mid-generation, with another step pending.
    gen_len_cfg = 40;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick(); tick();
    upd_we = 1'b1; upd_addr = 12'h0AB; upd_wdata = 16'h5555; step_req = 1'b1;
    #3 check("pre_rst_gnt", 32'(upd_gnt), 32'd1);
    check("pre_rst_we", 32'(mem_we), 32'd1);
    tick();
    step_req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("arst_gnt", 32'(upd_gnt), 32'd0);
    check("arst_we",   32'(mem_we),   32'd0);
    check("arst_addr", 32'(mem_addr), 32'(rend_addr));
    tick(); tick();
    rst_n = 1'b1;
    upd_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3 check("post_rst_start", 32'(upd_start), 32'd0);
      check("post_rst_gnt", 32'(upd_gnt), 32'd0);
      tick();
    end

    // Randomized traffic, checked every cycle by the model.
    gen_len_cfg = 0;
    blank_left  = 0;
    ack_seen    = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (blank_left == 0) begin
        done       = ~done;
        blank_left = done ? int'($urandom_range(2, 30)) : int'($urandom_range(1, 12));
      end
      blank_left--;
      rend_addr = LMA'($urandom);
      upd_addr  = LMA'($urandom);
      upd_we    = 1'($urandom);
      upd_wdata = WS'($urandom);
      step_req  = ($urandom_range(0, 9) == 0);
      if (ack_seen) begin
        edit_req = 1'b0;
      end else if (!edit_req && $urandom_range(0, 15) == 0) begin
        edit_req  = 1'b1;
        edit_addr = LMA'($urandom_range(0, 15));
        edit_bit  = LWS'($urandom);
      end
      #3 ack_seen = edit_ack;
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Sequences and shares the single board-memory read/write port between three requesters: the renderer's fetch stage, the generation updater and the user cell-edit path.
- The renderer owns the port unconditionally while the frame is being drawn.
- During the blank period (renderer done high), the arbiter first serves a pending cell edit as a read-modify-write, then starts or resumes the generation updater.
- Sits between the renderer/updater/input logic and the board BRAM.

Parameters:
- WORD_SIZE, 16, bits per memory word (one bit per cell, MSB-first).
- LOG_WORD_SIZE, 4, log2(WORD_SIZE).
- LOG_MAX_ADDR, 12, memory address width.
- READ_LATENCY, 2, BRAM read latency in cycles (at least 1).

Ports:
- clk_130mhz  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- render_done_in  in  1  renderer done_out; high = port free (blank).
- render_addr_in  in  LOG_MAX_ADDR  renderer read address.
- step_req_in  in  1  one-cycle pulse: request one generation.
- upd_start_out  out  1  one-cycle pulse: updater begins a generation.
- upd_busy_in  in  1  updater mid-generation.
- upd_gnt_out  out  1  updater may drive the port this cycle.
- upd_addr_in  in  LOG_MAX_ADDR  updater address.
- upd_we_in  in  1  updater write enable.
- upd_wdata_in  in  WORD_SIZE  updater write data.
- edit_req_in  in  1  level; hold until edit_ack_out.
- edit_addr_in  in  LOG_MAX_ADDR  word holding the cell.
- edit_bit_in  in  LOG_WORD_SIZE  cell index within the word.
- edit_ack_out  out  1  one-cycle pulse: toggle committed.
- mem_addr_out  out  LOG_MAX_ADDR  BRAM address.
- mem_we_out  out  1  BRAM write enable.
- mem_wdata_out  out  WORD_SIZE  BRAM write data.
- mem_rdata_in  in  WORD_SIZE  BRAM read data.

Behaviour:
- Reset (rst_in low, asynchronous):
  - state = IDLE, step_pending = 0.
  - upd_start_out, upd_gnt_out, edit_ack_out, mem_we_out = 0.
  - mem_wdata_out = 0; mem_addr_out follows render_addr_in.
- Port mux (combinational from registered state):
  - render_done_in low: mem_addr_out = render_addr_in and mem_we_out = 0, in every state. This adds zero latency to the renderer path.
  - UPDATE with render_done_in high: upd_gnt_out = 1; mem_* = upd_*.
  - EDIT_RD / EDIT_WAIT: address = edit_addr_in latched at entry, we = 0.
  - EDIT_WR: address = latched edit address, we = 1, wdata = read word XOR (1 << (WORD_SIZE-1-bit)).
- step_pending:
  - Set by step_req_in; cleared when upd_start_out fires.
  - Extra requests while pending coalesce.
  - A request arriving in UPDATE sets pending for the next generation.
- States:
  - IDLE, render_done_in high, edit_req_in high, upd_busy_in low -> EDIT_RD (latch edit address and bit).
  - IDLE, render_done_in high, no edit, step_pending -> pulse upd_start_out, -> UPDATE.
  - IDLE, upd_busy_in high (generation paused at a previous frame start), render_done_in high -> UPDATE, no start pulse.
  - EDIT_RD (1 cycle) -> EDIT_WAIT, which holds READ_LATENCY-1 cycles and captures mem_rdata_in on the last one -> EDIT_WR (1 cycle, write, edit_ack_out = 1) -> IDLE.
  - UPDATE: the updater must raise upd_busy_in within 1 cycle of the start pulse. upd_busy_in low from the 2nd UPDATE cycle on -> IDLE.
- Edits have priority over starting a generation. Edits never run while upd_busy_in is high (a generation is in flight), so a generation completes before any edit is applied.
- render_done_in falling mid-operation:
  - UPDATE: upd_gnt_out drops in the same cycle. The updater stalls with state held; state -> IDLE and resumes at the next blank.
  - EDIT_*: abort, suppress the write, no ack. The request stays held and is retried in full at the next blank.
- Simultaneous edit_req_in and step_req_in in IDLE: the edit goes first; step is latched as pending.
- Edit toggle is MSB-first: bit 0 = word MSB.

Optional Feature:
- Macro: ARB_OVERRUN_DETECT_EN.
- Defined: adds output overrun_out (1 bit, reset 0) and a 16-bit saturating counter overrun_count_out.
  - A render_done_in falling edge while upd_busy_in is high sets overrun_out (sticky until reset) and increments the counter.
  - Used to flag generations that span more than one blank.
- Undefined: neither port exists; pausing is silent.

Test Plan:
- Reset mid-UPDATE: assert rst_in low -> upd_gnt_out = 0 and mem_we_out = 0 immediately (asynchronous); state IDLE, pending cleared.
- Renderer priority: render_done_in = 0, edit_req_in = 1, step_req_in pulse -> mem_addr_out tracks render_addr_in every cycle; mem_we_out = 0; no ack, no start.
- Edit RMW:
  - Stimulus: done = 1, word 0x005 holds 0x8001, edit_bit_in = 15.
  - Response: read of 0x005 issued; after READ_LATENCY, write 0x8000 to 0x005; edit_ack_out one pulse.
  - Then bit 0 on 0x8000 -> write 0x0000.
- Step during blank: step_req_in pulse with done = 1 -> upd_start_out pulse next cycle; upd_gnt_out high while upd_busy_in is high; returns to IDLE 1 cycle after busy falls.
- Blank ends mid-generation: done falls while busy -> gnt low the same cycle. Next done rise -> gnt restored with no second start pulse (overrun_out = 1 and count = 1 if ARB_OVERRUN_DETECT_EN).
- Abort edit: done falls in EDIT_WAIT -> no write, no ack; edit completes in the next blank.
